mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-cache read/write requests for one
// instruction at a time, maintains the LL/SC link register with snoop
// invalidation, and registers the result toward the MEM/WB register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  input  logic [5:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_store,
  input  logic              in_regw,
  input  logic [1:0]        in_regdest,
  input  logic [ADDR_W-1:0] in_npc,
  input  logic              in_halt,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] dload,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [ADDR_W-1:0] dstore,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_data,
  output logic              out_regw,
  output logic [1:0]        out_regdest,
  output logic [ADDR_W-1:0] out_npc,
  output logic              out_halt,
  output logic              err
);

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_LL = 6'h30;
  localparam logic [5:0] OP_SC = 6'h38;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t              r_state, w_next;
  logic                r_halted;
  logic                r_link_valid;
  logic [ADDR_W-1:2]   r_link_addr;
  logic [ADDR_W-1:0]   r_addr, r_store, r_npc;
  logic                r_regw, r_halt, r_is_ll, r_is_sc;
  logic [1:0]          r_regdest;
  logic [31:0]         r_cnt;

  logic                w_accept, w_op_ld, w_op_ll, w_op_sw, w_op_sc;
  logic                w_snoop_link, w_snoop_req, w_sc_ok, w_wr_link;
  logic [1:0]          w_unused_snoop_lsb;

  assign w_accept     = (r_state == IDLE) && in_valid && !r_halted;
  assign w_op_ll      = (in_opcode == OP_LL);
  assign w_op_ld      = (in_opcode == OP_LW) || w_op_ll;
  assign w_op_sw      = (in_opcode == OP_SW);
  assign w_op_sc      = (in_opcode == OP_SC);
  assign w_snoop_link = snoop_valid && r_link_valid &&
                        (snoop_addr[ADDR_W-1:2] == r_link_addr);
  assign w_snoop_req  = snoop_valid && (snoop_addr[ADDR_W-1:2] == r_addr[ADDR_W-1:2]);
  assign w_sc_ok      = r_link_valid && (r_link_addr == in_addr[ADDR_W-1:2]) && !w_snoop_link;
  assign w_wr_link    = r_link_valid && (r_link_addr == r_addr[ADDR_W-1:2]);
  assign w_unused_snoop_lsb = snoop_addr[1:0];

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and cache request outputs, decoded from state only
  always_comb begin
    w_next = r_state;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    busy   = (r_state != IDLE) || r_halted;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_op_ld)                 w_next = RD;
          else if (w_op_sw)            w_next = WR;
          else if (w_op_sc && w_sc_ok) w_next = WR;
        end
      end
      RD: begin
        dREN  = 1'b1;
        daddr = r_addr;
        if (dhit) w_next = IDLE;
      end
      WR: begin
        dWEN   = 1'b1;
        daddr  = r_addr;
        dstore = r_store;
        if (dhit) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latched fields, link register, wait counter and registered results
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_halted     <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
      r_addr       <= '0;
      r_store      <= '0;
      r_npc        <= '0;
      r_regw       <= 1'b0;
      r_regdest    <= '0;
      r_halt       <= 1'b0;
      r_is_ll      <= 1'b0;
      r_is_sc      <= 1'b0;
      r_cnt        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_regw     <= 1'b0;
      out_regdest  <= '0;
      out_npc      <= '0;
      out_halt     <= 1'b0;
      err          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_snoop_link) r_link_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr    <= in_addr;
            r_store   <= in_store;
            r_npc     <= in_npc;
            r_regw    <= in_regw;
            r_regdest <= in_regdest;
            r_halt    <= in_halt;
            r_is_ll   <= w_op_ll;
            r_is_sc   <= w_op_sc;
            r_cnt     <= '0;
            if (in_halt) r_halted <= 1'b1;
            if (!(w_op_ld || w_op_sw || (w_op_sc && w_sc_ok))) begin
              // non-memory op or failed SC completes without a cache request
              out_valid   <= 1'b1;
              out_data    <= w_op_sc ? '0 : in_addr;
              out_regw    <= in_regw;
              out_regdest <= in_regdest;
              out_npc     <= in_npc;
              out_halt    <= in_halt;
              if (w_op_sc) r_link_valid <= 1'b0;
            end
          end
        end
        RD, WR: begin
          if (dhit) begin
            out_valid   <= 1'b1;
            out_regw    <= r_regw;
            out_regdest <= r_regdest;
            out_npc     <= r_npc;
            out_halt    <= r_halt;
            r_cnt       <= '0;
            if (r_state == RD) begin
              out_data <= dload;
              // placed after the snoop clear so a new link to a different
              // word survives, while a snoop on the LL word blocks the set
              if (r_is_ll && !w_snoop_req) begin
                r_link_valid <= 1'b1;
                r_link_addr  <= r_addr[ADDR_W-1:2];
              end
            end else begin
              out_data <= r_is_sc ? ADDR_W'(1) : r_addr;
              if (w_wr_link) r_link_valid <= 1'b0;
            end
          end else begin
            if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
            if ((TIMEOUT != 0) && (r_cnt >= TIMEOUT - 1)) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by
// randomized traffic, checked against a transaction-level LL/SC model.
module tb_mem_stage;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  logic        CLK = 1'b0;
  logic        nRST, in_valid, in_regw, in_halt, dhit, snoop_valid;
  logic [5:0]  in_opcode;
  logic [31:0] in_addr, in_store, in_npc, dload, snoop_addr;
  logic [1:0]  in_regdest;
  logic        dREN, dWEN, busy, out_valid, out_regw, out_halt, err;
  logic [31:0] daddr, dstore, out_data, out_npc;
  logic [1:0]  out_regdest;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // transaction-level link model: valid flag plus linked word address
  bit          m_link_v = 1'b0;
  logic [29:0] m_link_w = '0;

  mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_addr(in_addr), .in_store(in_store), .in_regw(in_regw),
    .in_regdest(in_regdest), .in_npc(in_npc), .in_halt(in_halt),
    .dhit(dhit), .dload(dload), .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_regw(out_regw), .out_regdest(out_regdest),
    .out_npc(out_npc), .out_halt(out_halt), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one idle cycle carrying a snoop
  task automatic snoop_cycle(input logic [31:0] a);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    step;
    snoop_valid = 1'b0;
    if (m_link_v && m_link_w == a[31:2]) m_link_v = 1'b0;
    check("snoop_idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // one instruction; d = cycles the request waits before the dhit cycle
  task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] st,
                       input int unsigned d, input bit snp, input logic [31:0] snp_a,
                       input bit halt);
    logic [31:0] dl, npc, exp_data;
    logic        regw;
    logic [1:0]  rd;
    bit          ld, wr, mem, sc_ok;
    dl    = $urandom;
    npc   = $urandom;
    regw  = 1'($urandom);
    rd    = 2'($urandom);
    ld    = (op == OP_LW) || (op == OP_LL);
    sc_ok = (op == OP_SC) && m_link_v && (m_link_w == addr[31:2]);
    wr    = (op == OP_SW) || sc_ok;
    mem   = ld || wr;
    exp_data = addr;

    check("busy_before_accept", {31'd0, busy}, 32'd0);
    in_valid = 1'b1; in_opcode = op; in_addr = addr; in_store = st;
    in_regw = regw; in_regdest = rd; in_npc = npc; in_halt = halt;
    step;
    in_valid = 1'b0;
    in_opcode = 6'($urandom); in_addr = $urandom; in_store = $urandom; in_halt = 1'b0;

    if (mem) begin
      for (int k = 0; k <= int'(d); k++) begin
        check("req_lines", {30'd0, dREN, dWEN}, ld ? 32'd2 : 32'd1);
        check("req_busy", {31'd0, busy}, 32'd1);
        check("req_daddr", daddr, addr);
        if (wr) check("req_dstore", dstore, st);
        check("req_no_valid", {31'd0, out_valid}, 32'd0);
        if (k == int'(d)) begin
          dhit = 1'b1; dload = dl;
          if (snp) begin snoop_valid = 1'b1; snoop_addr = snp_a; end
        end
        step;
      end
      dhit = 1'b0; snoop_valid = 1'b0; dload = $urandom;
      if (snp && m_link_v && m_link_w == snp_a[31:2]) m_link_v = 1'b0;
      if (op == OP_LL && !(snp && snp_a[31:2] == addr[31:2])) begin
        m_link_v = 1'b1;
        m_link_w = addr[31:2];
      end
      if (wr && m_link_v && m_link_w == addr[31:2]) m_link_v = 1'b0;
      if (ld) exp_data = dl;
      else if (op == OP_SC) exp_data = 32'd1;
      check("req_dropped", {30'd0, dREN, dWEN}, 32'd0);
    end else begin
      if (op == OP_SC) begin
        exp_data = 32'd0;
        m_link_v = 1'b0;
      end
      check("no_request", {30'd0, dREN, dWEN}, 32'd0);
    end

    check("out_valid", {31'd0, out_valid}, 32'd1);
    if (op != OP_SW) check("out_data", out_data, exp_data);
    check("out_regw", {31'd0, out_regw}, {31'd0, regw});
    check("out_regdest", {30'd0, out_regdest}, {30'd0, rd});
    check("out_npc", out_npc, npc);
    check("out_halt", {31'd0, out_halt}, {31'd0, halt});
    check("err_clear", {31'd0, err}, 32'd0);
    step;
    check("out_valid_pulse", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [5:0]  ops [5];
    logic [31:0] a;
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h2FC;
    ops[0] = OP_ADD; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_LL; ops[4] = OP_SC;

    nRST = 1'b0; in_valid = 1'b0; in_opcode = '0; in_addr = '0; in_store = '0;
    in_regw = 1'b0; in_regdest = '0; in_npc = '0; in_halt = 1'b0;
    dhit = 1'b0; dload = '0; snoop_valid = 1'b0; snoop_addr = '0;
    step; step;
    check("rst_req", {30'd0, dREN, dWEN}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_pass", {out_npc[29:0], out_regw, out_halt}, 32'd0);
    check("rst_regdest", {30'd0, out_regdest}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    nRST = 1'b1;
    step;

    // plan 1-3: ALU pass-through, load with wait, store
    do_op(OP_ADD, 32'h1234, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    check("alu_busy_after", {31'd0, busy}, 32'd0);
    do_op(OP_LW, 32'h40, 32'h0, 2, 1'b0, 32'h0, 1'b0);
    do_op(OP_SW, 32'h80, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b0);

    // plan 4: LL/SC success, unrelated snoop, killing snoop
    do_op(OP_LL, 32'h100, 32'h0, 1, 1'b0, 32'h0, 1'b0);
    do_op(OP_SC, 32'h100, 32'h11, 0, 1'b0, 32'h0, 1'b0);
    do_op(OP_LL, 32'h100, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    snoop_cycle(32'h104);
    do_op(OP_SC, 32'h100, 32'h22, 1, 1'b0, 32'h0, 1'b0);
    do_op(OP_LL, 32'h100, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    snoop_cycle(32'h100);
    do_op(OP_SC, 32'h100, 32'h33, 0, 1'b0, 32'h0, 1'b0);

    // plan 5: snoop coincident with the LL dhit wins
    do_op(OP_LL, 32'h100, 32'h0, 1, 1'b1, 32'h100, 1'b0);
    do_op(OP_SC, 32'h100, 32'h44, 0, 1'b0, 32'h0, 1'b0);

    // randomized traffic over a small address pool
    for (int n = 0; n < 60; n++) begin
      a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) snoop_cycle(pool[$urandom_range(0, 3)]);
      do_op(ops[$urandom_range(0, 4)], a, $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), pool[$urandom_range(0, 3)], 1'b0);
    end

    // halt: reported with its result, then all input ignored
    do_op(OP_ADD, 32'h55, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    in_valid = 1'b1; in_opcode = OP_LW; in_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      check("halted_busy", {31'd0, busy}, 32'd1);
      check("halted_no_req", {30'd0, dREN, dWEN}, 32'd0);
      check("halted_no_valid", {31'd0, out_valid}, 32'd0);
      step;
    end
    in_valid = 1'b0;

    // plan 6: timeout sets err after 4 wait cycles; reset mid-wait discards
    nRST = 1'b0; step; nRST = 1'b1;
    check("halt_cleared_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b1; in_opcode = OP_LW; in_addr = 32'h40;
    step;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("to_dren", {31'd0, dREN}, 32'd1);
      check("to_err", {31'd0, err}, (k >= 4) ? 32'd1 : 32'd0);
      step;
    end
    nRST = 1'b0;
    step;
    nRST = 1'b1;
    check("rstmid_dren", {31'd0, dREN}, 32'd0);
    check("rstmid_err", {31'd0, err}, 32'd0);
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    step;
    check("rstmid_valid2", {31'd0, out_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
